// File: rtl/req_ack_pkg.sv
// Shared types and defaults for the req/ack sink: handshake FSM states and default data width.
package req_ack_pkg;

  localparam int REQ_ACK_DATA_W = 4;

  typedef enum logic [0:0] {
    IDLE,
    WAIT_LOW
  } state_e;

endpackage

// File: rtl/req_ack_sink_if.sv
// Bundles the driver-side req/ack handshake and the downstream valid/ready stream.
// Optional REQ_ACK_SINK_XFER_CNT_EN adds the xfer_cnt and stall observation signals.
interface req_ack_sink_if #(
  parameter int DATA_W = req_ack_pkg::REQ_ACK_DATA_W,
  parameter int DEPTH  = 4
);

  localparam int FW = $clog2(DEPTH) + 1;

  logic              data_req;
  logic [DATA_W-1:0] data;
  logic              data_ack;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [FW-1:0]     fill;
`ifdef REQ_ACK_SINK_XFER_CNT_EN
  logic [15:0]       xfer_cnt;
  logic              stall;
`endif

  modport master (
    output data_req, data, out_ready,
`ifdef REQ_ACK_SINK_XFER_CNT_EN
    input  xfer_cnt, stall,
`endif
    input  data_ack, out_data, out_valid, fill
  );

  modport slave (
    input  data_req, data, out_ready,
`ifdef REQ_ACK_SINK_XFER_CNT_EN
    output xfer_cnt, stall,
`endif
    output data_ack, out_data, out_valid, fill
  );

endinterface

// File: rtl/req_ack_sink_fifo.sv
// First-word-fall-through FIFO: dout always shows the head entry; push is refused when full
// and pop is ignored when empty, so the occupancy can never over- or underflow.
module req_ack_sink_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (fill_q != FW'(DEPTH));
  assign do_pop  = pop && (fill_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout = mem_q[rd_ptr_q];
  assign fill = fill_q;

endmodule

// File: rtl/req_ack_sink.sv
// 4-phase req/ack sink in the clk_b domain: synchronises data_req, captures data into a FWFT FIFO
// and withholds data_ack while the FIFO is full. REQ_ACK_SINK_XFER_CNT_EN adds xfer_cnt and stall.
module req_ack_sink
  import req_ack_pkg::*;
#(
  parameter int DATA_W      = REQ_ACK_DATA_W,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_b,
  input  logic         rst,
  req_ack_sink_if.slave bus
);

  localparam int FW = $clog2(DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic                   req_s;
  logic                   push;
  logic                   full;
  logic [FW-1:0]          fill;

  assign req_s = sync_q[SYNC_STAGES-1];
  assign full  = (fill == FW'(DEPTH));

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], bus.data_req};
    state_d = state_q;
    ack_d   = ack_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        // While full the request simply waits here with ack low until a pop frees space.
        if (req_s && !full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_b) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  req_ack_sink_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk  (clk_b),
    .rst  (rst),
    .push (push),
    .din  (bus.data),
    .pop  (bus.out_ready && bus.out_valid),
    .dout (bus.out_data),
    .fill (fill)
  );

  assign bus.data_ack  = ack_q;
  assign bus.fill      = fill;
  assign bus.out_valid = (fill != '0);

`ifdef REQ_ACK_SINK_XFER_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = push ? xfer_cnt_q + 16'd1 : xfer_cnt_q;
  end

  always_ff @(posedge clk_b) begin
    if (rst) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign bus.xfer_cnt = xfer_cnt_q;
  assign bus.stall    = (state_q == IDLE) && req_s && full;
`endif

endmodule

// File: doc/req_ack_sink.md
Name: req_ack_sink

Overview:
- Single-clock sink for the 4-phase req/ack data handshake used between data_driver and data_receiver.
- Sits in the clk_b domain. It synchronises the incoming data_req, captures data, and returns data_ack.
- Captured words are buffered in a small first-word-fall-through FIFO and presented on a valid/ready stream to downstream logic.
- Back-pressure: data_ack is withheld while the FIFO is full, so no word is ever dropped.

Parameters:
- DATA_W, 4, width of data and out_data.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, flops in the data_req synchroniser; minimum 2.

Ports:
- clk_b  input  1  sole clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_req  input  1  request from the driver; asynchronous to clk_b.
- data  input  DATA_W  payload; the driver holds it stable while data_req is high.
- data_ack  output  1  registered acknowledge to the driver.
- out_data  output  DATA_W  head of FIFO.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  downstream accepts out_data when out_valid && out_ready.
- fill  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Interface: one clock (clk_b); reset rst is synchronous and active-high.
- Reset values: data_ack=0, out_valid=0, fill=0, pointers=0, synchroniser flops=0, state=IDLE. out_data is don't-care while out_valid=0.
- req_s is data_req delayed through SYNC_STAGES flops. data is sampled only when req_s=1; the driver guarantees it is stable by then.
- FSM state IDLE:
  - if req_s=1 and fill<DEPTH: write data to mem[wr_ptr], increment wr_ptr, set data_ack=1, go to WAIT_LOW.
  - if req_s=1 and fill==DEPTH: stay in IDLE with data_ack=0 (stall) until space frees.
- FSM state WAIT_LOW:
  - hold data_ack=1 until req_s=0, then data_ack=0 and return to IDLE.
  - data_req re-rising before ack is observed low is a driver protocol violation; behaviour is not defined.
- Latency: with data_req rising just before edge N and FIFO not full, the word is written and data_ack=1 after edge N+SYNC_STAGES. That is 3 clk_b edges at default. data_ack falls SYNC_STAGES+1 edges after data_req falls.
- Pop: on an edge where out_valid && out_ready, increment rd_ptr.
- Occupancy:
  - fill: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - The push decision uses the registered fill, so at fill==DEPTH a same-cycle pop does not enable a push. The push happens one cycle later.
- Pointers wrap modulo DEPTH.
- FIFO output: out_data=mem[rd_ptr] combinationally (first-word fall-through); out_valid=(fill!=0).
- No overflow or underflow is possible. A pop while empty is ignored.
- Reset mid-handshake: all state clears and data_ack drops after the reset edge. If data_req is still high after reset release, it is treated as a new transfer and the word is captured again.

Optional Feature:
- Macro REQ_ACK_SINK_XFER_CNT_EN.
- Defined: adds output xfer_cnt [15:0]. It resets to 0, increments on every FIFO push, and wraps 0xFFFF->0. Also adds output stall, high in every cycle where state==IDLE, req_s=1 and fill==DEPTH.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package req_ack_pkg:
  - state enum {IDLE, WAIT_LOW};
  - default data width constant REQ_ACK_DATA_W=4.
- Sub-module req_ack_sink_fifo:
  - parameterised FWFT FIFO (DATA_W, DEPTH) with push, pop, fill, dout.
  - The top keeps the synchroniser and handshake FSM.

Test Plan:
- Single transfer: after reset, data=4'hA with data_req high, out_ready=1. Expect data_ack=1 on the 3rd clk_b edge, out_data=4'hA with out_valid for 1 cycle. Drop data_req: data_ack=0 three edges later.
- Fill and stall: out_ready=0, send 4'h1..4'h5. Expect 4 acks and fill=4; the 5th data_req gets no ack (stall=1 if enabled). Raise out_ready: pop 1,2,3,4; the 5th is acked and popped in order.
- Simultaneous push/pop: fill=2, a pop coincides with a push edge. Expect fill stays 2 and order is preserved.
- Wrap-around: 10 back-to-back transfers of 0..9 with out_ready toggling each cycle. Expect output sequence 0..9 exactly; pointers wrap twice.
- Reset mid-handshake: assert rst for 1 cycle while in WAIT_LOW with data_req held high. Expect data_ack=0 and fill=0, then a re-capture of the same word 3 edges after release.
- With REQ_ACK_SINK_XFER_CNT_EN: 5 transfers, then xfer_cnt=5. Preload-free wrap check: 65537 transfers give xfer_cnt=1.
